// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants and helpers for the pipeline stream blocks
package pipeline_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_RATIO     = 16;

  function automatic int lane_bits(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/pipeline_beat_counter.sv
// rtl/pipeline_beat_counter.sv - wrapping 0..RATIO-1 beat counter shared by packer and unpacker
module pipeline_beat_counter
  import pipeline_pkg::*;
#(
  parameter int RATIO = 4,
  parameter int CW    = lane_bits(RATIO)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          is_last
);

  assign is_last = (count == CW'(RATIO - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= is_last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_packer.sv
// rtl/pipeline_packer.sv - WIDTH to WIDTH*RATIO stream upsizer; PIPELINE_PACKER_LAST_EN adds last/keep
module pipeline_packer
  import pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int RATIO = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       up_data,
  input  logic                   up_valid,
  output logic                   up_ready,
`ifdef PIPELINE_PACKER_LAST_EN
  input  logic                   up_last,
  output logic                   down_last,
  output logic [RATIO-1:0]       down_keep,
`endif
  output logic [WIDTH*RATIO-1:0] down_data,
  output logic                   down_valid,
  input  logic                   down_ready
);

  localparam int CW = lane_bits(RATIO);

  generate
    if (RATIO < 2 || RATIO > MAX_RATIO) begin : g_bad_ratio
      $error("pipeline_packer: RATIO must be in 2..%0d", MAX_RATIO);
    end
  endgenerate

  logic [CW-1:0]          cnt;
  logic                   is_last;
  logic                   final_beat;
  logic                   accept;
  logic [WIDTH*RATIO-1:0] asm_q;
  logic [WIDTH*RATIO-1:0] word_next;

`ifdef PIPELINE_PACKER_LAST_EN
  assign final_beat = is_last | up_last;
`else
  assign final_beat = is_last;
`endif

  // Only the word-closing beat can stall, and only behind an unaccepted output word.
  assign up_ready = final_beat ? (!down_valid | down_ready) : 1'b1;
  assign accept   = up_valid & up_ready;

  pipeline_beat_counter #(.RATIO(RATIO), .CW(CW)) u_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (accept & !final_beat),
    .clear   (accept & final_beat),
    .count   (cnt),
    .is_last (is_last)
  );

  // Lanes above the closing beat are zero so an early-terminated word carries no stale data.
  always_comb begin
    word_next = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k < int'(cnt)) begin
        word_next[k*WIDTH +: WIDTH] = asm_q[k*WIDTH +: WIDTH];
      end else if (k == int'(cnt)) begin
        word_next[k*WIDTH +: WIDTH] = up_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      asm_q <= '0;
    end else if (accept && !final_beat) begin
      for (int k = 0; k < RATIO; k++) begin
        if (k == int'(cnt)) begin
          asm_q[k*WIDTH +: WIDTH] <= up_data;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      down_data  <= '0;
      down_valid <= 1'b0;
    end else if (accept && final_beat) begin
      down_data  <= word_next;
      down_valid <= 1'b1;
    end else if (down_valid && down_ready) begin
      down_valid <= 1'b0;
    end
  end

`ifdef PIPELINE_PACKER_LAST_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      down_last <= 1'b0;
      down_keep <= '0;
    end else if (accept && final_beat) begin
      down_last <= up_last;
      for (int k = 0; k < RATIO; k++) begin
        down_keep[k] <= (k <= int'(cnt));
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_packer.sv
// tb/tb_pipeline_packer.sv - scoreboard bench for pipeline_packer (WIDTH=8, RATIO=4)
module tb_pipeline_packer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  up_data;
  logic        up_valid;
  logic        up_ready;
  logic        up_last;
  logic [31:0] down_data;
  logic        down_valid;
  logic        down_ready;
`ifdef PIPELINE_PACKER_LAST_EN
  logic        down_last;
  logic [3:0]  down_keep;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [4:0]  exp_keep_q[$];
  logic [7:0]  beat_buf[$];

  always #5 clock = ~clock;

  pipeline_packer #(.WIDTH(8), .RATIO(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
`ifdef PIPELINE_PACKER_LAST_EN
    .up_last    (up_last),
    .down_last  (down_last),
    .down_keep  (down_keep),
`endif
    .down_data  (down_data),
    .down_valid (down_valid),
    .down_ready (down_ready)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference model: builds expected words from accepted beats; compares outputs at transfer.
  always @(negedge clock) begin
    if (!reset_n) begin
      beat_buf.delete();
      exp_q.delete();
      exp_keep_q.delete();
    end else begin
      if (down_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", down_data, 32'hxxxxxxxx);
        end else if (down_ready) begin
          check("word", down_data, exp_q[0]);
`ifdef PIPELINE_PACKER_LAST_EN
          check("keep_last", {27'd0, down_last, down_keep}, {27'd0, exp_keep_q[0]});
`endif
          void'(exp_q.pop_front());
          void'(exp_keep_q.pop_front());
        end else begin
          check("held_word", down_data, exp_q[0]);
        end
      end
      if (up_valid && up_ready) begin
        logic [31:0] w;
        logic [3:0]  keep;
        bit          lst;
        beat_buf.push_back(up_data);
        lst = 1'b0;
`ifdef PIPELINE_PACKER_LAST_EN
        lst = up_last;
`endif
        if (beat_buf.size() == 4 || lst) begin
          w = '0;
          keep = '0;
          for (int k = 0; k < beat_buf.size(); k++) begin
            w[k*8 +: 8] = beat_buf[k];
            keep[k] = 1'b1;
          end
          exp_q.push_back(w);
          exp_keep_q.push_back({lst, keep});
          beat_buf.delete();
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l, output int waits);
    up_data  = d;
    up_valid = 1'b1;
    up_last  = l;
    waits    = 0;
    @(negedge clock);
    while (!up_ready && waits < 50) begin
      waits++;
      @(negedge clock);
    end
    if (!up_ready) check("beat_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    up_valid = 1'b0;
    up_last  = 1'b0;
    up_data  = 8'hEE;
  endtask

  task automatic drain();
    int n;
    down_ready = 1'b1;
    n = 0;
    while ((down_valid || exp_q.size() != 0) && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain_valid", {31'd0, down_valid}, 32'd0);
    check("drain_queue", exp_q.size(), 32'd0);
  endtask

  initial begin
    int w;
    int stalls;
    reset_n    = 1'b0;
    up_data    = 8'h00;
    up_valid   = 1'b0;
    up_last    = 1'b0;
    down_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_down_valid", {31'd0, down_valid}, 32'd0);
    check("rst_down_data", down_data, 32'd0);
    check("rst_up_ready", {31'd0, up_ready}, 32'd1);
    reset_n = 1'b1;
    up_data = 8'h5A;
    repeat (3) @(posedge clock);
    #1;
    check("idle_down_valid", {31'd0, down_valid}, 32'd0);
    check("idle_down_data", down_data, 32'd0);
    check("idle_up_ready", {31'd0, up_ready}, 32'd1);

    // Basic pack with one-cycle output latency
    send_beat(8'h11, 1'b0, w);
    send_beat(8'h22, 1'b0, w);
    send_beat(8'h33, 1'b0, w);
    send_beat(8'h44, 1'b0, w);
    check("basic_valid", {31'd0, down_valid}, 32'd1);
    check("basic_data", down_data, 32'h44332211);
    @(posedge clock);
    #1;
    check("basic_valid_drop", {31'd0, down_valid}, 32'd0);

    // Back-to-back streaming
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      send_beat(8'(i), 1'b0, w);
      stalls += w;
    end
    check("stream_stalls", stalls, 32'd0);
    drain();

    // Backpressure: word 1 held, final beat of word 2 stalls
    down_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(8'hA0 + 8'(i), 1'b0, w);
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      send_beat(8'hB0 + 8'(i), 1'b0, w);
      stalls += w;
    end
    check("bp_early_stalls", stalls, 32'd0);
    up_data  = 8'hB3;
    up_valid = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("bp_final_stall", {31'd0, up_ready}, 32'd0);
      check("bp_hold_data", down_data, 32'hA3A2A1A0);
    end
    @(posedge clock);
    #1;
    down_ready = 1'b1;
    @(negedge clock);
    check("bp_release_ready", {31'd0, up_ready}, 32'd1);
    @(posedge clock);
    #1;
    up_valid = 1'b0;
    check("bp_word2_valid", {31'd0, down_valid}, 32'd1);
    check("bp_word2_data", down_data, 32'hB3B2B1B0);
    drain();

    // Reset mid-word discards the partial word
    send_beat(8'hAA, 1'b0, w);
    send_beat(8'hBB, 1'b0, w);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) send_beat(8'(i), 1'b0, w);
    check("rstmid_data", down_data, 32'h04030201);
    drain();

`ifdef PIPELINE_PACKER_LAST_EN
    // Early termination with up_last
    send_beat(8'h55, 1'b0, w);
    send_beat(8'h66, 1'b1, w);
    check("last_data", down_data, 32'h00006655);
    check("last_keep", {28'd0, down_keep}, 32'h3);
    check("last_flag", {31'd0, down_last}, 32'd1);
    for (int i = 0; i < 4; i++) send_beat(8'hC0 + 8'(i), 1'b0, w);
    check("after_last_data", down_data, 32'hC3C2C1C0);
    check("after_last_keep", {28'd0, down_keep}, 32'hF);
    check("after_last_flag", {31'd0, down_last}, 32'd0);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_packer.md
Name: pipeline_packer

Overview:
Stream width upsizer that sits directly upstream of the pipeline skid-buffer stage. It collects RATIO consecutive WIDTH-bit beats from a valid/ready source and emits them as one WIDTH*RATIO-bit word on a registered valid/ready output. Its output feeds the skid-buffer stage's up_* port unchanged. It sustains one input beat per cycle when downstream is ready.

Parameters:
WIDTH, 8, bits per input beat
RATIO, 4, input beats per output word; legal range 2..16, other values are an elaboration error

Ports:
clock  input  1  clock; all state updates on posedge
reset_n  input  1  reset, asynchronous, active-low
up_data  input  WIDTH  input beat
up_valid  input  1  input beat valid
up_ready  output  1  packer accepts beat this cycle
down_data  output  WIDTH*RATIO  packed word, registered
down_valid  output  1  packed word valid, registered
down_ready  input  1  downstream accepts word this cycle

Behaviour:
- Reset values (async, reset_n low): lane counter cnt=0, assembly register=0, down_data=0, down_valid=0. up_ready is combinational and reads 1 during reset.
- Transfers: an input beat transfers when up_valid & up_ready; an output word transfers when down_valid & down_ready.
- Lane order is little-endian. Beat k of a word (k=0..RATIO-1) lands in bits [k*WIDTH +: WIDTH].
- cnt counts accepted beats of the current word, 0..RATIO-1, using $clog2(RATIO) bits.
- While cnt < RATIO-1:
  - up_ready=1.
  - An accepted beat is written into assembly lane cnt, and cnt increments.
- When cnt == RATIO-1 (final beat):
  - up_ready = !down_valid | down_ready.
  - On acceptance: down_data <= {up_data, assembly lanes RATIO-2..0}; down_valid <= 1; cnt <= 0 (wraps).
- down_valid clears on an output transfer with no final-beat acceptance in the same cycle.
- Simultaneous output transfer and final-beat acceptance: down_valid stays 1 and down_data is replaced. No bubble.
- Latency: down_valid rises on the clock edge that accepts the final beat, so it is visible the next cycle.
- Throughput: 1 beat/cycle sustained while down_ready=1, giving one word every RATIO cycles.
- Backpressure:
  - Only the final beat can stall.
  - Partial assembly lanes are held indefinitely.
  - down_data and down_valid are stable while down_valid & !down_ready.
- up_data is ignored whenever up_valid=0. Assembly lanes are not cleared between words; stale lanes are always overwritten before they are emitted.
- Mid-operation reset discards any partial word and any pending output word.

Optional Feature:
Macro PIPELINE_PACKER_LAST_EN.
- Defined: adds ports up_last (input, 1), down_last (output, 1, reset 0) and down_keep (output, RATIO, reset 0).
  - A beat accepted with up_last=1 finalises the word immediately, even if cnt < RATIO-1. That beat uses the final-beat ready rule.
  - Unfilled lanes are emitted as zero.
  - down_keep[k]=1 for each filled lane; down_last=1; cnt <= 0.
  - Full words without last: down_keep = all ones, down_last=0.
- Undefined: the three ports do not exist, and behaviour is exactly as described above.

Decomposition:
- Shared package pipeline_pkg:
  - default beat width constant (8)
  - maximum RATIO constant (16)
  - lane-index width function wrapping $clog2
- One sub-module, pipeline_beat_counter:
  - wrapping 0..RATIO-1 counter with inc, clear and is_last outputs
  - reused later by the matching downsizer

Test Plan:
(WIDTH=8, RATIO=4 unless stated.)
- Reset state: reset_n low -> down_valid=0, down_data=0, up_ready=1; release reset -> state unchanged until up_valid.
- Basic pack: beats 0x11,0x22,0x33,0x44 on consecutive cycles with down_ready=1 -> down_data=0x44332211 with down_valid=1 one cycle after 0x44 is accepted; down_valid low the following cycle.
- Back-to-back streaming: 16 beats 0x00..0x0F with up_valid=1 and down_ready=1 -> words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, each one cycle apart per 4 beats; up_ready never low.
- Backpressure: down_ready=0 while two full words arrive -> first word held stable; up_ready=1 for beats 0-2 of word 2, up_ready=0 at beat 3; raise down_ready -> word 2 is accepted that same cycle, word 1 unloads, and no beat is lost.
- Reset mid-word: accept 0xAA,0xBB, assert reset_n low for one cycle, then send 0x01..0x04 -> down_data=0x04030201 only; 0xAA and 0xBB never appear.
- With PIPELINE_PACKER_LAST_EN: beats 0x55,0x66 with up_last on 0x66 -> down_data=0x00006655, down_keep=4'b0011, down_last=1; next word starts at lane 0.
